scan_clk_div_arbiter: RTL and testbench

- Shares the single odd-ratio scan-clock divider between N_REQ requesters.
- Each requester asks for a divisor. The block grants one requester at a time (round-robin) and sequences the divider safely: reset hold, divisor load, release, settle. It then signals ready and keeps the clock until the owner drops its request.
- Sits between the scan engines and the divider's i_rst/i_divisor inputs. No divisor change ever reaches a running divider.

---
 rtl/scan_clk_pkg.sv | 20 ++
 rtl/scan_clk_div_arbiter_rr_pick.sv | 40 ++++
 rtl/scan_clk_div_arbiter.sv | 173 +++++++++++++++++
 tb/tb_scan_clk_div_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_clk_pkg.sv
// Shared definitions for the scan-clock divider arbiter.
//   state_e        : arbiter sequencing states
//   DIV_W_DEF      : default divisor width
//   HOLD_CYC_DEF   : default cycles the divider is held in reset before release
//   SETTLE_CYC_DEF : default base settle time after divider release
package scan_clk_pkg;

  localparam int unsigned DIV_W_DEF      = 16;
  localparam int unsigned HOLD_CYC_DEF   = 4;
  localparam int unsigned SETTLE_CYC_DEF = 16;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StSettle,
    StOwn,
    StRelease
  } state_e;

endpackage

// File: rtl/scan_clk_div_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request at or after
// the pointer, wrapping modulo N_REQ.
//   i_req : request vector
//   i_ptr : round-robin start index
//   o_gnt : one-hot winner (zero when no request)
//   o_idx : winner index (zero when no request)
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  logic             w_found;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_k;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_k     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // ptr + i < 2*N_REQ, so a single conditional subtract wraps it.
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
      w_k   = (w_sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ))
                                           : IDX_W'(w_sum);
      if (!w_found && i_req[w_k]) begin
        w_found    = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

endmodule

// File: rtl/scan_clk_div_arbiter.sv
// Shares one odd-ratio scan-clock divider between N_REQ requesters. Grants
// round-robin, then sequences the divider: reset hold, divisor load, release,
// settle, ready. The divisor only changes while the divider is in reset.
//   i_clk       : system clock (also clocks the divider)
//   i_rst       : asynchronous active-low reset
//   i_req       : per-requester request level, held for the whole ownership
//   i_div       : packed divisors, requester k at [k*DIV_W +: DIV_W]
//   o_gnt       : one-hot grant, zero when no owner
//   o_ready     : divided clock stable for the owner
//   o_div_rst_n : divider reset (0 = reset/bypass)
//   o_divisor   : divider divisor
//   o_busy      : arbiter not idle
module scan_clk_div_arbiter
  import scan_clk_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DIV_W      = DIV_W_DEF,
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*DIV_W-1:0] i_div,
  output logic [N_REQ-1:0]       o_gnt,
  output logic                   o_ready,
  output logic                   o_div_rst_n,
  output logic [DIV_W-1:0]       o_divisor,
  output logic                   o_busy
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = DIV_W + 2;

  state_e           r_state,     w_state_d;
  logic [N_REQ-1:0] r_gnt,       w_gnt_d;
  logic             r_ready,     w_ready_d;
  logic             r_div_rst_n, w_div_rst_n_d;
  logic [DIV_W-1:0] r_divisor,   w_divisor_d;
  logic             r_busy,      w_busy_d;
  logic [IDX_W-1:0] r_ptr,       w_ptr_d;
  logic [IDX_W-1:0] r_owner,     w_owner_d;
  logic [CNT_W-1:0] r_cnt,       w_cnt_d;

  logic [N_REQ-1:0] w_pick_gnt;
  logic [IDX_W-1:0] w_pick_idx;
  logic [DIV_W-1:0] w_sel_div;
  logic [DIV_W:0]   w_twice_div;
  logic [CNT_W-1:0] w_settle_load;
  logic             w_owner_req;
  logic             w_release;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  always_comb begin
    w_sel_div = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_pick_idx == IDX_W'(k)) w_sel_div = i_div[k*DIV_W +: DIV_W];
    end
  end

  // Widened so SETTLE_CYC + 2*0xFFFF cannot wrap.
  assign w_twice_div   = {r_divisor, 1'b0};
  assign w_settle_load = CNT_W'(SETTLE_CYC) + CNT_W'(w_twice_div);
  assign w_owner_req   = i_req[r_owner];

  always_comb begin
    w_state_d     = r_state;
    w_gnt_d       = r_gnt;
    w_ready_d     = r_ready;
    w_div_rst_n_d = r_div_rst_n;
    w_divisor_d   = r_divisor;
    w_ptr_d       = r_ptr;
    w_owner_d     = r_owner;
    w_cnt_d       = r_cnt;
    w_release     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (|i_req) begin
          w_state_d   = StHold;
          w_gnt_d     = w_pick_gnt;
          w_owner_d   = w_pick_idx;
          w_divisor_d = w_sel_div;
          w_cnt_d     = CNT_W'(HOLD_CYC - 1);
        end
      end
      StHold: begin
        if (!w_owner_req) begin
          w_release = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_d     = StSettle;
          w_div_rst_n_d = 1'b1;
          w_cnt_d       = w_settle_load;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      StSettle: begin
        if (!w_owner_req) begin
          w_release = 1'b1;
        end else if (r_cnt <= CNT_W'(1)) begin
          // Counter hits zero on this update; ready rises with it.
          w_state_d = StOwn;
          w_ready_d = 1'b1;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      StOwn: begin
        if (!w_owner_req) w_release = 1'b1;
      end
      StRelease: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    if (w_release) begin
      w_state_d     = StRelease;
      w_gnt_d       = '0;
      w_ready_d     = 1'b0;
      w_div_rst_n_d = 1'b0;
      w_divisor_d   = '0;
      w_cnt_d       = '0;
      w_ptr_d       = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
    end

    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= StIdle;
      r_gnt       <= '0;
      r_ready     <= 1'b0;
      r_div_rst_n <= 1'b0;
      r_divisor   <= '0;
      r_busy      <= 1'b0;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_gnt       <= w_gnt_d;
      r_ready     <= w_ready_d;
      r_div_rst_n <= w_div_rst_n_d;
      r_divisor   <= w_divisor_d;
      r_busy      <= w_busy_d;
      r_ptr       <= w_ptr_d;
      r_owner     <= w_owner_d;
      r_cnt       <= w_cnt_d;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_ready     = r_ready;
  assign o_div_rst_n = r_div_rst_n;
  assign o_divisor   = r_divisor;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_scan_clk_div_arbiter.sv
// Directed bench for scan_clk_div_arbiter. Inputs change and outputs are
// sampled on the falling clock edge; the design acts on the rising edge.
module tb_scan_clk_div_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] div;
  logic [3:0]  gnt;
  logic        ready;
  logic        div_rst_n;
  logic [15:0] divisor;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int n;

  scan_clk_div_arbiter dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_req       (req),
    .i_div       (div),
    .o_gnt       (gnt),
    .o_ready     (ready),
    .o_div_rst_n (div_rst_n),
    .o_divisor   (divisor),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int cnt);
    repeat (cnt) begin
      @(negedge clk);
      if (ready) begin
        check("inv_ready_rst_n", {31'd0, div_rst_n}, 32'd1);
        check("inv_ready_onehot", {31'd0, $onehot(gnt)}, 32'd1);
      end
    end
  endtask

  // Cycles from now until ready, capped so a stuck design cannot hang the run.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 200) begin
      cyc(1);
      cnt++;
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    req   = 4'b0000;
    cyc(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    div   = '0;
    #1;
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_div_rst_n", {31'd0, div_rst_n}, 32'd0);
    check("rst_divisor", {16'd0, divisor}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    cyc(2);

    // Single requester, divisor 3: settle = 16 + 6 = 22.
    rst_n = 1'b1;
    div   = {16'd0, 16'd0, 16'd0, 16'd3};
    req   = 4'b0001;
    cyc(1);
    check("single_gnt", {28'd0, gnt}, 32'h1);
    check("single_divisor", {16'd0, divisor}, 32'd3);
    check("single_hold_start", {31'd0, div_rst_n}, 32'd0);
    check("single_busy", {31'd0, busy}, 32'd1);
    cyc(3);
    check("single_hold_end", {31'd0, div_rst_n}, 32'd0);
    cyc(1);
    check("single_release", {31'd0, div_rst_n}, 32'd1);
    check("single_divisor_rel", {16'd0, divisor}, 32'd3);
    cyc(21);
    check("single_not_ready", {31'd0, ready}, 32'd0);
    cyc(1);
    check("single_ready", {31'd0, ready}, 32'd1);
    check("single_gnt_own", {28'd0, gnt}, 32'h1);
    check("single_divisor_own", {16'd0, divisor}, 32'd3);
    req = 4'b0000;
    cyc(1);
    check("rel_gnt", {28'd0, gnt}, 32'd0);
    check("rel_ready", {31'd0, ready}, 32'd0);
    check("rel_div_rst_n", {31'd0, div_rst_n}, 32'd0);
    check("rel_divisor", {16'd0, divisor}, 32'd0);
    check("rel_busy", {31'd0, busy}, 32'd1);
    cyc(1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Contention, divisor 0 everywhere: hold 4 + settle 16.
    div = '0;
    reset_pulse();
    req = 4'b1111;
    cyc(1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("cont_gnt_%0d", k), {28'd0, gnt}, 32'(1) << (k % 4));
      wait_ready(n);
      check($sformatf("cont_lat_%0d", k), n, 32'd20);
      check($sformatf("cont_div0_%0d", k), {16'd0, divisor}, 32'd0);
      cyc(10);
      check($sformatf("cont_hold_own_%0d", k), {31'd0, ready}, 32'd1);
      req[k % 4] = 1'b0;
      cyc(1);
      check($sformatf("cont_gap1_%0d", k), {28'd0, gnt}, 32'd0);
      req[k % 4] = 1'b1;
      cyc(1);
      check($sformatf("cont_gap2_%0d", k), {28'd0, gnt}, 32'd0);
      cyc(1);
    end

    // Pointer wrap: owner 2 releases, pointer 3, req 0011 -> grant 0.
    div = {16'd9, 16'd7, 16'd5, 16'd3};
    reset_pulse();
    req = 4'b0100;
    cyc(1);
    check("wrap_first_gnt", {28'd0, gnt}, 32'h4);
    check("wrap_first_div", {16'd0, divisor}, 32'd7);
    wait_ready(n);
    check("wrap_first_lat", n, 32'd34);
    req = 4'b0011;
    cyc(2);
    check("wrap_gap", {28'd0, gnt}, 32'd0);
    cyc(1);
    check("wrap_gnt", {28'd0, gnt}, 32'h1);
    check("wrap_div", {16'd0, divisor}, 32'd3);

    // Abort during SETTLE: requester 1 withdraws, pointer moves to 2.
    reset_pulse();
    req = 4'b0010;
    cyc(1);
    check("abort_gnt", {28'd0, gnt}, 32'h2);
    cyc(6);
    check("abort_in_settle", {31'd0, div_rst_n}, 32'd1);
    check("abort_no_ready_settle", {31'd0, ready}, 32'd0);
    req = 4'b0000;
    cyc(1);
    check("abort_rel_gnt", {28'd0, gnt}, 32'd0);
    check("abort_rel_rst_n", {31'd0, div_rst_n}, 32'd0);
    check("abort_rel_ready", {31'd0, ready}, 32'd0);
    check("abort_rel_divisor", {16'd0, divisor}, 32'd0);
    req = 4'b0101;
    cyc(2);
    check("abort_ptr_gnt", {28'd0, gnt}, 32'h4);

    // Frozen divisor while owning.
    div = {16'd0, 16'd0, 16'd0, 16'd5};
    reset_pulse();
    req = 4'b0001;
    cyc(1);
    check("frozen_gnt", {28'd0, gnt}, 32'h1);
    wait_ready(n);
    check("frozen_lat", n, 32'd30);
    div = {16'd0, 16'd0, 16'd0, 16'd7};
    cyc(3);
    check("frozen_divisor", {16'd0, divisor}, 32'd5);
    check("frozen_rst_n", {31'd0, div_rst_n}, 32'd1);
    check("frozen_ready", {31'd0, ready}, 32'd1);
    req = 4'b0000;
    cyc(2);
    check("frozen_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-SETTLE; pointer (1 here) must return to 0.
    div = {16'd9, 16'd7, 16'd5, 16'd3};
    req = 4'b0100;
    cyc(1);
    check("mid_gnt", {28'd0, gnt}, 32'h4);
    cyc(6);
    check("mid_in_settle", {31'd0, div_rst_n}, 32'd1);
    #2;
    rst_n = 1'b0;
    req   = 4'b0011;
    #1;
    check("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_div_rst_n", {31'd0, div_rst_n}, 32'd0);
    check("mid_rst_divisor", {16'd0, divisor}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    check("mid_after_gnt", {28'd0, gnt}, 32'h1);
    check("mid_after_div", {16'd0, divisor}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
